// File: rtl/cache_axi_pkg.sv
// -----------------------------------------------------------------------------
// cache_axi_pkg
// Shared constants and types for the cache read-miss to AXI4 read bridge.
//   - request type encodings seen on rd_type
//   - fixed AXI4 read-address field values (burst, size, line length)
//   - bridge state enum
//   - helper that forms the AR address from a latched request
// -----------------------------------------------------------------------------
package cache_axi_pkg;

  localparam logic       RD_TYPE_WORD   = 1'b0;
  localparam logic       RD_TYPE_LINE   = 1'b1;

  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [2:0] AXI_SIZE_4B    = 3'b010;
  localparam logic [7:0] LINE_ARLEN     = 8'd3;
  localparam logic [7:0] WORD_ARLEN     = 8'd0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_AR   = 2'd1,
    ST_R    = 2'd2,
    ST_RESP = 2'd3
  } rd_state_e;

  // Line fetches start at the 16-byte boundary; word fetches use the exact address.
  function automatic logic [31:0] ar_addr_for(input logic rd_type, input logic [31:0] addr);
    if (rd_type == RD_TYPE_LINE) begin
      return {addr[31:4], 4'b0000};
    end
    return addr;
  endfunction

endpackage

// File: rtl/axi_rd_beat_assembler.sv
// -----------------------------------------------------------------------------
// axi_rd_beat_assembler
// Packs up to four 32-bit R beats into a 128-bit buffer, beat i landing in
// bits [32*i+:32]. A 2-bit beat counter selects the slot and wraps.
// Ports:
//   clk, resetn      clock, synchronous active-low reset
//   clear            zero the counter and buffer (new request accepted)
//   beat_we          capture rdata into the current slot and advance
//   rdata [31:0]     incoming beat
//   buf_data [127:0] assembled buffer, held until the next clear
// -----------------------------------------------------------------------------
module axi_rd_beat_assembler (
  input  logic         clk,
  input  logic         resetn,
  input  logic         clear,
  input  logic         beat_we,
  input  logic [31:0]  rdata,
  output logic [127:0] buf_data
);

  logic [1:0]   cnt_q, cnt_d;
  logic [127:0] buf_q, buf_d;

  // Clear wins over a write so a fresh request always starts from an empty buffer.
  always_comb begin
    cnt_d = cnt_q;
    buf_d = buf_q;
    if (clear) begin
      cnt_d = 2'd0;
      buf_d = '0;
    end else if (beat_we) begin
      cnt_d = cnt_q + 2'd1;
      case (cnt_q)
        2'd0:    buf_d[31:0]   = rdata;
        2'd1:    buf_d[63:32]  = rdata;
        2'd2:    buf_d[95:64]  = rdata;
        default: buf_d[127:96] = rdata;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      cnt_q <= 2'd0;
      buf_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      buf_q <= buf_d;
    end
  end

  assign buf_data = buf_q;

endmodule

// File: rtl/cache_axi_rd_bridge.sv
// -----------------------------------------------------------------------------
// cache_axi_rd_bridge
// Turns one L1 cache read miss into one AXI4 read (single word or 4-beat INCR
// line), collects the R beats and returns them as a 128-bit ret_data with a
// one-cycle ret_valid pulse. Only one transaction is in flight at a time.
// Ports:
//   clk, resetn                         clock, synchronous active-low reset
//   rd_req/rd_type/rd_addr, rd_rdy      cache request side (accept on rd_req && rd_rdy)
//   ret_valid, ret_data                 cache return side
//   ar*                                 AXI4 read address channel (master)
//   rid/rdata/rresp/rlast/rvalid/rready AXI4 read data channel
// Optional build macro CACHE_RD_PERF_CNT_EN adds perf_req_cnt, perf_wait_cnt
// and the sticky perf_rresp_err outputs; without it rresp is not used.
// -----------------------------------------------------------------------------
module cache_axi_rd_bridge
  import cache_axi_pkg::*;
#(
  parameter int unsigned ID_WIDTH = 4,
  parameter int unsigned AXI_ID   = 0
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic                rd_req,
  input  logic                rd_type,
  input  logic [31:0]         rd_addr,
  output logic                rd_rdy,
  output logic                ret_valid,
  output logic [127:0]        ret_data,
  output logic [ID_WIDTH-1:0] arid,
  output logic [31:0]         araddr,
  output logic [7:0]          arlen,
  output logic [2:0]          arsize,
  output logic [1:0]          arburst,
  output logic [1:0]          arlock,
  output logic [3:0]          arcache,
  output logic [2:0]          arprot,
  output logic                arvalid,
  input  logic                arready,
  input  logic [ID_WIDTH-1:0] rid,
  input  logic [31:0]         rdata,
  input  logic [1:0]          rresp,
  input  logic                rlast,
  input  logic                rvalid,
  output logic                rready
`ifdef CACHE_RD_PERF_CNT_EN
  ,
  output logic [31:0]         perf_req_cnt,
  output logic [31:0]         perf_wait_cnt,
  output logic                perf_rresp_err
`endif
);

  rd_state_e   state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic        type_q, type_d;
  logic        buf_clear;
  logic        beat_we;
  logic        accept;

  // With a single outstanding read the response ID carries no information.
  logic [ID_WIDTH-1:0] unused_rid;
  assign unused_rid = rid;

  // Next-state and handshake outputs. Every output here is a function of the
  // registered state (plus the channel inputs for transitions), so rd_rdy
  // never depends on rd_req.
  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    type_d    = type_q;
    rd_rdy    = 1'b0;
    arvalid   = 1'b0;
    rready    = 1'b0;
    ret_valid = 1'b0;
    buf_clear = 1'b0;
    beat_we   = 1'b0;
    accept    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        rd_rdy = 1'b1;
        if (rd_req) begin
          accept    = 1'b1;
          addr_d    = rd_addr;
          type_d    = rd_type;
          buf_clear = 1'b1;
          state_d   = ST_AR;
        end
      end
      ST_AR: begin
        arvalid = 1'b1;
        if (arready) begin
          state_d = ST_R;
        end
      end
      ST_R: begin
        rready = 1'b1;
        if (rvalid) begin
          beat_we = 1'b1;
          // An early rlast ends the burst; unfilled slots stay zero.
          if (rlast) begin
            state_d = ST_RESP;
          end
        end
      end
      ST_RESP: begin
        ret_valid = 1'b1;
        state_d   = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      type_q  <= RD_TYPE_WORD;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      type_q  <= type_d;
    end
  end

  // AR fields come only from the latched request so they stay stable while
  // arvalid waits for arready.
  assign arid    = ID_WIDTH'(AXI_ID);
  assign araddr  = ar_addr_for(type_q, addr_q);
  assign arlen   = (type_q == RD_TYPE_LINE) ? LINE_ARLEN : WORD_ARLEN;
  assign arsize  = AXI_SIZE_4B;
  assign arburst = AXI_BURST_INCR;
  assign arlock  = 2'b00;
  assign arcache = 4'b0000;
  assign arprot  = 3'b000;

  axi_rd_beat_assembler u_beat_asm (
    .clk      (clk),
    .resetn   (resetn),
    .clear    (buf_clear),
    .beat_we  (beat_we),
    .rdata    (rdata),
    .buf_data (ret_data)
  );

`ifdef CACHE_RD_PERF_CNT_EN
  logic [31:0] perf_req_cnt_q, perf_req_cnt_d;
  logic [31:0] perf_wait_cnt_q, perf_wait_cnt_d;
  logic        perf_rresp_err_q, perf_rresp_err_d;

  // Counters wrap naturally at 2^32; the error flag is sticky until reset.
  always_comb begin
    perf_req_cnt_d   = perf_req_cnt_q;
    perf_wait_cnt_d  = perf_wait_cnt_q;
    perf_rresp_err_d = perf_rresp_err_q;
    if (accept) begin
      perf_req_cnt_d = perf_req_cnt_q + 32'd1;
    end
    if ((state_q == ST_AR) || (state_q == ST_R)) begin
      perf_wait_cnt_d = perf_wait_cnt_q + 32'd1;
    end
    if (beat_we && (rresp != 2'b00)) begin
      perf_rresp_err_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      perf_req_cnt_q   <= '0;
      perf_wait_cnt_q  <= '0;
      perf_rresp_err_q <= 1'b0;
    end else begin
      perf_req_cnt_q   <= perf_req_cnt_d;
      perf_wait_cnt_q  <= perf_wait_cnt_d;
      perf_rresp_err_q <= perf_rresp_err_d;
    end
  end

  assign perf_req_cnt   = perf_req_cnt_q;
  assign perf_wait_cnt  = perf_wait_cnt_q;
  assign perf_rresp_err = perf_rresp_err_q;
`else
  logic [1:0] unused_rresp;
  logic       unused_accept;
  assign unused_rresp  = rresp;
  assign unused_accept = accept;
`endif

endmodule

// File: tb/tb_cache_axi_rd_bridge.sv
// -----------------------------------------------------------------------------
// tb_cache_axi_rd_bridge
// Directed bench for cache_axi_rd_bridge. Inputs are driven 1 time unit after
// each rising edge and outputs are sampled at the same point, away from the edge.
// -----------------------------------------------------------------------------
module tb_cache_axi_rd_bridge;

  logic         clk;
  logic         resetn;
  logic         rd_req;
  logic         rd_type;
  logic [31:0]  rd_addr;
  logic         rd_rdy;
  logic         ret_valid;
  logic [127:0] ret_data;
  logic [3:0]   arid;
  logic [31:0]  araddr;
  logic [7:0]   arlen;
  logic [2:0]   arsize;
  logic [1:0]   arburst;
  logic [1:0]   arlock;
  logic [3:0]   arcache;
  logic [2:0]   arprot;
  logic         arvalid;
  logic         arready;
  logic [3:0]   rid;
  logic [31:0]  rdata;
  logic [1:0]   rresp;
  logic         rlast;
  logic         rvalid;
  logic         rready;
`ifdef CACHE_RD_PERF_CNT_EN
  logic [31:0]  perf_req_cnt;
  logic [31:0]  perf_wait_cnt;
  logic         perf_rresp_err;
`endif

  int passCount  = 0;
  int totalCount = 0;
  int cyc        = 0;
  int acceptCyc  = 0;
  int arCount    = 0;
  int retCount   = 0;

  cache_axi_rd_bridge #(.ID_WIDTH(4), .AXI_ID(0)) dut (
    .clk       (clk),
    .resetn    (resetn),
    .rd_req    (rd_req),
    .rd_type   (rd_type),
    .rd_addr   (rd_addr),
    .rd_rdy    (rd_rdy),
    .ret_valid (ret_valid),
    .ret_data  (ret_data),
    .arid      (arid),
    .araddr    (araddr),
    .arlen     (arlen),
    .arsize    (arsize),
    .arburst   (arburst),
    .arlock    (arlock),
    .arcache   (arcache),
    .arprot    (arprot),
    .arvalid   (arvalid),
    .arready   (arready),
    .rid       (rid),
    .rdata     (rdata),
    .rresp     (rresp),
    .rlast     (rlast),
    .rvalid    (rvalid),
    .rready    (rready)
`ifdef CACHE_RD_PERF_CNT_EN
    ,
    .perf_req_cnt   (perf_req_cnt),
    .perf_wait_cnt  (perf_wait_cnt),
    .perf_rresp_err (perf_rresp_err)
`endif
  );

  // Free-running clock, 10 time units per cycle.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Count AR handshakes and return pulses so stray or missing ones are caught.
  always @(posedge clk) begin
    if (arvalid && arready) arCount <= arCount + 1;
    if (ret_valid) retCount <= retCount + 1;
  end

  task automatic step();
    @(posedge clk);
    #1;
    cyc = cyc + 1;
  endtask

  task automatic checkOutput(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    totalCount = totalCount + 1;
    assert (obs === exp) passCount = passCount + 1;
    else $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic applyStimulus(input logic req, input logic typ, input logic [31:0] addr);
    rd_req  = req;
    rd_type = typ;
    rd_addr = addr;
  endtask

  // Entered in the first AR cycle. Holds arready low for waitCycles while
  // presenting junk R beats that must be ignored, then completes the handshake.
  task automatic doAr(input int waitCycles, input logic [31:0] expAddr, input logic [7:0] expLen);
    for (int i = 0; i < waitCycles; i++) begin
      arready = 1'b0;
      rvalid  = 1'b1;
      rlast   = 1'b1;
      rdata   = 32'hBAD0_0000 + i;
      checkOutput("ar_wait_valid", arvalid, 1'b1);
      checkOutput("ar_wait_addr", araddr, expAddr);
      checkOutput("ar_wait_len", arlen, expLen);
      checkOutput("ar_wait_rready", rready, 1'b0);
      step();
    end
    rvalid = 1'b0;
    rlast  = 1'b0;
    checkOutput("ar_valid", arvalid, 1'b1);
    checkOutput("ar_addr", araddr, expAddr);
    checkOutput("ar_len", arlen, expLen);
    checkOutput("ar_size", arsize, 3'b010);
    checkOutput("ar_burst", arburst, 2'b01);
    arready = 1'b1;
    step();
    arready = 1'b0;
    checkOutput("r_rready", rready, 1'b1);
    checkOutput("r_arvalid_low", arvalid, 1'b0);
  endtask

  // Idles the R channel for gap cycles (junk data, rlast high but rvalid low),
  // then presents one beat.
  task automatic beat(input int gap, input logic [31:0] d, input logic last, input logic [1:0] resp);
    for (int i = 0; i < gap; i++) begin
      rvalid = 1'b0;
      rlast  = 1'b1;
      rdata  = 32'hDEAD_0000 + i;
      step();
    end
    rvalid = 1'b1;
    rdata  = d;
    rlast  = last;
    rresp  = resp;
    step();
    rvalid = 1'b0;
    rlast  = 1'b0;
    rresp  = 2'b00;
  endtask

  initial begin
    resetn  = 1'b0;
    arready = 1'b0;
    rvalid  = 1'b0;
    rlast   = 1'b0;
    rdata   = '0;
    rresp   = 2'b00;
    rid     = '0;
    applyStimulus(1'b0, 1'b0, 32'h0);
    step();
    step();
    step();
    resetn = 1'b1;
    step();

    // Reset state
    checkOutput("rst_rd_rdy", rd_rdy, 1'b1);
    checkOutput("rst_ret_valid", ret_valid, 1'b0);
    checkOutput("rst_arvalid", arvalid, 1'b0);
    checkOutput("rst_rready", rready, 1'b0);
    checkOutput("rst_ret_data", ret_data, 128'h0);

    // 1: line read, slave answers one cycle after the AR handshake with no gaps
    applyStimulus(1'b1, 1'b1, 32'h1FC0_0014);
    acceptCyc = cyc;
    step();
    applyStimulus(1'b0, 1'b0, 32'h0);
    checkOutput("t1_rd_rdy_busy", rd_rdy, 1'b0);
    checkOutput("t1_arid", arid, 4'h0);
    doAr(0, 32'h1FC0_0010, 8'd3);
    beat(1, 32'h11, 1'b0, 2'b00);
    beat(0, 32'h22, 1'b0, 2'b00);
    beat(0, 32'h33, 1'b0, 2'b00);
    beat(0, 32'h44, 1'b1, 2'b00);
    checkOutput("t1_ret_valid", ret_valid, 1'b1);
    checkOutput("t1_latency", cyc - acceptCyc, 7);
    checkOutput("t1_ret_data", ret_data, 128'h00000044_00000033_00000022_00000011);
    step();
    checkOutput("t1_ret_pulse", ret_valid, 1'b0);
    checkOutput("t1_rd_rdy_back", rd_rdy, 1'b1);
    checkOutput("t1_data_hold", ret_data, 128'h00000044_00000033_00000022_00000011);

    // 2: single word read
    applyStimulus(1'b1, 1'b0, 32'hBFAF_8000);
    step();
    applyStimulus(1'b0, 1'b0, 32'h0);
    doAr(0, 32'hBFAF_8000, 8'd0);
    beat(0, 32'hDEAD_BEEF, 1'b1, 2'b00);
    checkOutput("t2_ret_valid", ret_valid, 1'b1);
    checkOutput("t2_ret_data", ret_data, {96'h0, 32'hDEAD_BEEF});
    step();

    // 3: AR stall of 5 cycles and gaps between beats
    applyStimulus(1'b1, 1'b1, 32'h0000_1238);
    step();
    applyStimulus(1'b0, 1'b0, 32'h0);
    doAr(5, 32'h0000_1230, 8'd3);
    beat(2, 32'hA1A1_A1A1, 1'b0, 2'b00);
    beat(0, 32'hA2A2_A2A2, 1'b0, 2'b00);
    beat(1, 32'hA3A3_A3A3, 1'b0, 2'b00);
    beat(3, 32'hA4A4_A4A4, 1'b1, 2'b00);
    checkOutput("t3_ret_valid", ret_valid, 1'b1);
    checkOutput("t3_ret_data", ret_data, 128'hA4A4A4A4_A3A3A3A3_A2A2A2A2_A1A1A1A1);
    step();

    // 3b: early rlast on beat 1 leaves the upper words zero
    applyStimulus(1'b1, 1'b1, 32'h0000_3000);
    step();
    applyStimulus(1'b0, 1'b0, 32'h0);
    doAr(0, 32'h0000_3000, 8'd3);
    beat(0, 32'hB1B1_B1B1, 1'b0, 2'b00);
    beat(0, 32'hB2B2_B2B2, 1'b1, 2'b00);
    checkOutput("t3b_ret_valid", ret_valid, 1'b1);
    checkOutput("t3b_ret_data", ret_data, 128'h00000000_00000000_B2B2B2B2_B1B1B1B1);
    step();

    // 4: rd_req held high, second request accepted right after the return pulse
    applyStimulus(1'b1, 1'b0, 32'h0000_0100);
    step();
    applyStimulus(1'b1, 1'b1, 32'h0000_2004);
    checkOutput("t4_busy_rd_rdy", rd_rdy, 1'b0);
    doAr(0, 32'h0000_0100, 8'd0);
    checkOutput("t4_r_rd_rdy", rd_rdy, 1'b0);
    beat(0, 32'hCAFE_0001, 1'b1, 2'b00);
    checkOutput("t4_ret_valid", ret_valid, 1'b1);
    checkOutput("t4_ret_data", ret_data, {96'h0, 32'hCAFE_0001});
    checkOutput("t4_resp_arvalid", arvalid, 1'b0);
    checkOutput("t4_resp_rd_rdy", rd_rdy, 1'b0);
    step();
    checkOutput("t4_idle_rd_rdy", rd_rdy, 1'b1);
    checkOutput("t4_idle_arvalid", arvalid, 1'b0);
    checkOutput("t4_idle_hold", ret_data, {96'h0, 32'hCAFE_0001});
    step();
    applyStimulus(1'b0, 1'b0, 32'h0);
    checkOutput("t4_cleared", ret_data, 128'h0);
    doAr(0, 32'h0000_2000, 8'd3);
    beat(0, 32'hC1, 1'b0, 2'b00);
    beat(0, 32'hC2, 1'b0, 2'b00);
    beat(0, 32'hC3, 1'b0, 2'b00);
    beat(0, 32'hC4, 1'b1, 2'b00);
    checkOutput("t4_ret2_data", ret_data, 128'h000000C4_000000C3_000000C2_000000C1);
    step();

    // 5: reset in the middle of the R phase aborts without a return pulse
    applyStimulus(1'b1, 1'b1, 32'h8000_0040);
    step();
    applyStimulus(1'b0, 1'b0, 32'h0);
    doAr(0, 32'h8000_0040, 8'd3);
    beat(0, 32'h55, 1'b0, 2'b00);
    beat(0, 32'h66, 1'b0, 2'b00);
    checkOutput("t5_in_r", rready, 1'b1);
    resetn = 1'b0;
    step();
    checkOutput("t5_rst_rd_rdy", rd_rdy, 1'b1);
    checkOutput("t5_rst_rready", rready, 1'b0);
    checkOutput("t5_rst_ret_valid", ret_valid, 1'b0);
    checkOutput("t5_rst_ret_data", ret_data, 128'h0);
    resetn = 1'b1;
    step();
    checkOutput("t5_no_ret", ret_valid, 1'b0);
    checkOutput("t5_ret_count", retCount, 6);
    checkOutput("t5_ar_count", arCount, 7);
    applyStimulus(1'b1, 1'b0, 32'h0000_0ABC);
    step();
    applyStimulus(1'b0, 1'b0, 32'h0);
    doAr(0, 32'h0000_0ABC, 8'd0);
    beat(0, 32'h1234_5678, 1'b1, 2'b00);
    checkOutput("t5_fresh_valid", ret_valid, 1'b1);
    checkOutput("t5_fresh_data", ret_data, {96'h0, 32'h1234_5678});
`ifdef CACHE_RD_PERF_CNT_EN
    checkOutput("t5_perf_req", perf_req_cnt, 32'd1);
    checkOutput("t5_perf_wait", perf_wait_cnt, 32'd2);
    checkOutput("t5_perf_err", perf_rresp_err, 1'b0);
`endif
    step();

`ifdef CACHE_RD_PERF_CNT_EN
    // 6: error response on beat 1 sets the sticky flag
    applyStimulus(1'b1, 1'b1, 32'h0000_0100);
    step();
    applyStimulus(1'b0, 1'b0, 32'h0);
    doAr(0, 32'h0000_0100, 8'd3);
    beat(0, 32'hE0, 1'b0, 2'b00);
    beat(0, 32'hE1, 1'b0, 2'b10);
    beat(0, 32'hE2, 1'b0, 2'b00);
    beat(0, 32'hE3, 1'b1, 2'b00);
    checkOutput("t6_err_set", perf_rresp_err, 1'b1);
    checkOutput("t6_req_cnt", perf_req_cnt, 32'd2);
    step();
    applyStimulus(1'b1, 1'b0, 32'h0000_0200);
    step();
    applyStimulus(1'b0, 1'b0, 32'h0);
    doAr(0, 32'h0000_0200, 8'd0);
    beat(0, 32'hF0, 1'b1, 2'b00);
    checkOutput("t6_err_sticky", perf_rresp_err, 1'b1);
    checkOutput("t6_req_cnt2", perf_req_cnt, 32'd3);
    step();
    checkOutput("end_ar_count", arCount, 10);
    checkOutput("end_ret_count", retCount, 9);
`else
    checkOutput("end_ar_count", arCount, 8);
    checkOutput("end_ret_count", retCount, 7);
`endif

    $display("%0d/%0d checks passed", passCount, totalCount);
    $finish;
  end

endmodule
